sram_ctrl_seq: RTL
==================

Name: sram_ctrl_seq

Overview:
Command sequencer in front of sram_top. It accepts parallel read/write requests over a valid/ready interface. Writes are serialised onto serial_in/shift (MSB first) and then committed with a w_en pulse. Reads are issued with an r_en pulse, and the block waits for data_valid with a timeout. Each completed command returns a one-cycle response pulse to the requester.

Parameters:
ROWS, 16, number of SRAM words; address width AW = $clog2(ROWS)
COLS, 8, word width in bits
SHIFT_CYCLES, 2, clock cycles each serial bit is held with shift=1 (minimum 1)
RD_TIMEOUT, 15, maximum WAIT_RD cycles before a read is flagged as an error (minimum 1)

Ports:
clk  in  1  system clock, rising edge
arst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  AW  target word address
req_wdata  in  COLS  write data
rsp_valid  out  1  one-cycle response pulse
rsp_err  out  1  qualifies rsp_valid: address out of range or read timeout
rsp_rdata  out  COLS  read data; 0 for writes and errors
busy  out  1  state != IDLE
serial_in  out  1  serial data to SRAM
shift  out  1  shift-register enable to SRAM
w_en  out  1  SRAM write strobe
r_en  out  1  SRAM read strobe
addr  out  AW  SRAM address
data_valid  in  1  SRAM read data valid
data_out  in  COLS  SRAM read data

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except req_ready=1; counters and capture registers cleared. Reset mid-operation aborts the command: no w_en/r_en is issued and no response is returned.
- States:
  - IDLE: req_ready=1.
  - SHIFT: serialising write data.
  - WRITE: w_en=1 for exactly one cycle.
  - READ: r_en=1 for exactly one cycle.
  - WAIT_RD: waiting for data_valid.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Accept: a handshake (req_valid & req_ready) in cycle T registers we/addr/wdata.
  - req_ready is combinationally 1 only in IDLE.
  - addr output follows the registered address from T+1 until RESP ends, and holds its last value afterwards.
- Range check: if req_addr >= ROWS (possible only when ROWS is not a power of 2), go IDLE->RESP with rsp_err=1 and rsp_valid at T+1. No SRAM strobes are issued.
- Write timing:
  - SHIFT covers cycles T+1 .. T+COLS*SHIFT_CYCLES. shift=1 throughout.
  - serial_in = wdata[COLS-1-k] during bit slot k (each slot SHIFT_CYCLES cycles).
  - WRITE at T+COLS*SHIFT_CYCLES+1, with serial_in and shift = 0.
  - RESP at T+COLS*SHIFT_CYCLES+2, with rsp_err=0 and rsp_rdata=0.
- Read timing:
  - READ at T+1 (r_en=1).
  - WAIT_RD from T+2, with cycle counter starting at 0.
  - data_valid is sampled in both READ and WAIT_RD. On the first data_valid=1 in cycle D, capture data_out and go to RESP at D+1 (rsp_err=0).
  - Each WAIT_RD cycle without data_valid increments the counter. At the cycle where counter == RD_TIMEOUT-1 with no data_valid, go to RESP with rsp_err=1 and rsp_rdata=0; rsp_valid occurs at T+2+RD_TIMEOUT.
  - data_valid arriving in that final cycle wins: data is returned, not an error.
- data_valid outside READ/WAIT_RD is ignored.
- shift, w_en and r_en are mutually exclusive in every cycle.
- All outputs are registered except req_ready and busy, which are decoded from state.
- No back-pressure on the response. A new request may be accepted in the cycle after RESP.

Decomposition:
- Package sram_ctrl_pkg:
  - state enum ctrl_state_e {IDLE, SHIFT, WRITE, READ, WAIT_RD, RESP};
  - default ROWS/COLS/SHIFT_CYCLES/RD_TIMEOUT localparams;
  - function slot_count(cols, sc) returning cols*sc.
- Sub-module sram_ser_shifter: parallel-to-serial shifter.
  - Inputs: load, load_data[COLS-1:0].
  - Outputs: serial_in and shift, each bit held SHIFT_CYCLES cycles, plus a done pulse on the last cycle.
  - Owns the bit counter and hold counter.

Test Plan:
- Write 8'hA5 to addr 3 (COLS=8, SHIFT_CYCLES=2), accept at T → shift=1 T+1..T+16; serial_in sequence 1,0,1,0,0,1,0,1, each held 2 cycles; w_en=1 only at T+17 with addr=3; rsp_valid at T+18, rsp_err=0.
- Read addr 3 with model asserting data_valid 3 cycles after r_en and data_out=8'hA5 → r_en at T+1 only; rsp_valid at T+5 with rsp_rdata=8'hA5, rsp_err=0.
- Read with data_valid never asserted (RD_TIMEOUT=15) → rsp_valid at T+17, rsp_err=1, rsp_rdata=0; req_ready=1 at T+18.
- Timeout boundary: data_valid asserted exactly at T+16 → rsp at T+17 with data and rsp_err=0.
- ROWS=12, request addr 13 → rsp_valid at T+1 with rsp_err=1; no shift/w_en/r_en ever asserted.
- Assert arst_n=0 at T+8 of a write → all outputs 0 immediately, no w_en; after release req_ready=1 and the next write completes normally.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM command sequencer.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WRITE,
    READ,
    WAIT_RD,
    RESP
  } ctrl_state_e;

  localparam int DEF_ROWS         = 16;
  localparam int DEF_COLS         = 8;
  localparam int DEF_SHIFT_CYCLES = 2;
  localparam int DEF_RD_TIMEOUT   = 15;

  function automatic int slot_count(input int cols, input int sc);
    return cols * sc;
  endfunction

endpackage

// File: rtl/sram_ser_shifter.sv
// Parallel-to-serial shifter: emits load_data MSB first, each bit held for
// SHIFT_CYCLES cycles with shift=1, and pulses done on the final cycle.
module sram_ser_shifter
  import sram_ctrl_pkg::*;
#(
  parameter int COLS         = DEF_COLS,
  parameter int SHIFT_CYCLES = DEF_SHIFT_CYCLES
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            load,
  input  logic [COLS-1:0] load_data,
  output logic            serial_in,
  output logic            shift,
  output logic            done
);

  localparam int HW = $clog2(SHIFT_CYCLES + 1);
  localparam int BW = $clog2(COLS + 1);

  logic [COLS-1:0] sreg;
  logic [HW-1:0]   hold_cnt;
  logic [BW-1:0]   bit_cnt;
  logic            last_hold;
  logic            last_bit;

  assign last_hold = (hold_cnt == HW'(SHIFT_CYCLES - 1));
  assign last_bit  = (bit_cnt == BW'(COLS - 1));
  assign done      = shift && last_hold && last_bit;

  // The current bit always sits in the MSB of sreg; clearing sreg after the
  // last slot returns serial_in to 0 without a separate output register.
  assign serial_in = sreg[COLS-1];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sreg     <= '0;
      shift    <= 1'b0;
      hold_cnt <= '0;
      bit_cnt  <= '0;
    end else if (load) begin
      sreg     <= load_data;
      shift    <= 1'b1;
      hold_cnt <= '0;
      bit_cnt  <= '0;
    end else if (shift) begin
      if (!last_hold) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
        if (last_bit) begin
          shift <= 1'b0;
          sreg  <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          sreg    <= sreg << 1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_ctrl_seq.sv
// Command sequencer in front of sram_top: serialises writes, issues reads with
// a timeout and returns a one-cycle response per command.
module sram_ctrl_seq
  import sram_ctrl_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int SHIFT_CYCLES = DEF_SHIFT_CYCLES,
  parameter int RD_TIMEOUT   = DEF_RD_TIMEOUT,
  localparam int AW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [COLS-1:0] rsp_rdata,
  output logic            busy,
  output logic            serial_in,
  output logic            shift,
  output logic            w_en,
  output logic            r_en,
  output logic [AW-1:0]   addr,
  input  logic            data_valid,
  input  logic [COLS-1:0] data_out
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [AW:0] ROWS_LIM = (AW + 1)'(ROWS);

  ctrl_state_e     state, next_state;
  logic [TW-1:0]   rd_cnt, rd_cnt_d;
  logic            load;
  logic            sh_done;
  logic            rsp_err_d;
  logic [COLS-1:0] rsp_rdata_d;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  sram_ser_shifter #(
    .COLS         (COLS),
    .SHIFT_CYCLES (SHIFT_CYCLES)
  ) u_shifter (
    .clk       (clk),
    .arst_n    (arst_n),
    .load      (load),
    .load_data (req_wdata),
    .serial_in (serial_in),
    .shift     (shift),
    .done      (sh_done)
  );

  // Response fields are only non-zero on the transition into RESP.
  always_comb begin
    next_state  = state;
    load        = 1'b0;
    rd_cnt_d    = rd_cnt;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if ({1'b0, req_addr} >= ROWS_LIM) begin
            next_state = RESP;
            rsp_err_d  = 1'b1;
          end else if (req_we) begin
            next_state = SHIFT;
            load       = 1'b1;
          end else begin
            next_state = READ;
          end
        end
      end
      SHIFT: begin
        if (sh_done) next_state = WRITE;
      end
      WRITE: next_state = RESP;
      READ: begin
        if (data_valid) begin
          next_state  = RESP;
          rsp_rdata_d = data_out;
        end else begin
          next_state = WAIT_RD;
          rd_cnt_d   = '0;
        end
      end
      WAIT_RD: begin
        if (data_valid) begin
          next_state  = RESP;
          rsp_rdata_d = data_out;
        end else if (rd_cnt == TW'(RD_TIMEOUT - 1)) begin
          next_state = RESP;
          rsp_err_d  = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt + 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      addr      <= '0;
      w_en      <= 1'b0;
      r_en      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= next_state;
      rd_cnt    <= rd_cnt_d;
      if (req_valid && req_ready) addr <= req_addr;
      w_en      <= (next_state == WRITE);
      r_en      <= (next_state == READ);
      rsp_valid <= (next_state == RESP);
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule
